// File: rtl/mig7_arbiter_pkg.sv
// Shared constants and types for the two-port MIG7 arbiter.
package mig7_arbiter_pkg;

  // MIG7 app_cmd encodings
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Sequencer state encodings
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_WR_ENC      = 3'd1;
  localparam logic [2:0] ST_RD_CMD_ENC  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WR      = ST_WR_ENC,
    ST_RD_CMD  = ST_RD_CMD_ENC,
    ST_RD_WAIT = ST_RD_WAIT_ENC,
    ST_DONE    = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/mig7_arbiter_if.sv
// Bundle of client req/done ports and the MIG7 app_* user interface.
// master = the arbiter, slave = clients plus MIG7 controller.
interface mig7_arbiter_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = 32
);
  logic                  init_calib_complete;

  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p0_done;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  p1_done;

  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic                  app_wdf_end;
  logic [MASK_WIDTH-1:0] app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;

  modport master (
    input  init_calib_complete,
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_done,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_done,
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    input  app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    output init_calib_complete,
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_done,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_done,
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    output app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/mig7_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that did not
// win last time is chosen.
module mig7_rr_pick2
  import mig7_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick a winner from the request vector and the previous grant
  always_comb begin
    grant_valid = req[0] | req[1];
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mig7_arbiter.sv
// Two-port arbiter/sequencer in front of the MIG7 app_* interface.
// One transaction at a time; all interface outputs come straight from flops.
module mig7_arbiter
  import mig7_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = 32
) (
  input  logic            ui_clk,
  input  logic            ui_clk_sync_rst,
  mig7_arbiter_if.master  bus
);

  // Beat-aligned addressing: the low five byte-address bits are dropped
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b00000};

  state_t                state_r,      state_s;
  logic                  last_grant_r, last_grant_s;
  logic                  gnt_r,        gnt_s;
  logic [ADDR_WIDTH-1:0] addr_r,       addr_s;
  logic [DATA_WIDTH-1:0] wdata_r,      wdata_s;
  logic [2:0]            app_cmd_r,    app_cmd_s;
  logic                  app_en_r,     app_en_s;
  logic                  app_wren_r,   app_wren_s;
  logic                  cmd_ok_r,     cmd_ok_s;
  logic                  dat_ok_r,     dat_ok_s;
  logic                  p0_done_r,    p0_done_s;
  logic                  p1_done_r,    p1_done_s;
  logic [DATA_WIDTH-1:0] p0_rdata_r,   p0_rdata_s;
  logic [DATA_WIDTH-1:0] p1_rdata_r,   p1_rdata_s;

  logic                  pick_valid_s;
  logic                  pick_idx_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  cmd_acc_s;
  logic                  dat_acc_s;

  mig7_rr_pick2 u_pick (
    .req         ({bus.p1_req, bus.p0_req}),
    .last_grant  (last_grant_r),
    .grant_valid (pick_valid_s),
    .grant_idx   (pick_idx_s)
  );

  assign cmd_acc_s = app_en_r & bus.app_rdy;
  assign dat_acc_s = app_wren_r & bus.app_wdf_rdy;

  // Route the picked port's request fields toward the latch registers
  always_comb begin
    if (pick_idx_s) begin
      sel_we_s    = bus.p1_we;
      sel_addr_s  = bus.p1_addr;
      sel_wdata_s = bus.p1_wdata;
    end else begin
      sel_we_s    = bus.p0_we;
      sel_addr_s  = bus.p0_addr;
      sel_wdata_s = bus.p0_wdata;
    end
  end

  // Next-state and next-output logic of the sequencer
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    gnt_s        = gnt_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    app_cmd_s    = app_cmd_r;
    app_en_s     = app_en_r;
    app_wren_s   = app_wren_r;
    cmd_ok_s     = cmd_ok_r;
    dat_ok_s     = dat_ok_r;
    p0_done_s    = 1'b0;
    p1_done_s    = 1'b0;
    p0_rdata_s   = p0_rdata_r;
    p1_rdata_s   = p1_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.init_calib_complete && pick_valid_s) begin
          gnt_s        = pick_idx_s;
          last_grant_s = pick_idx_s;
          addr_s       = sel_addr_s & ADDR_MASK;
          wdata_s      = sel_wdata_s;
          app_en_s     = 1'b1;
          cmd_ok_s     = 1'b0;
          dat_ok_s     = 1'b0;
          if (sel_we_s) begin
            app_cmd_s  = MIG_CMD_WRITE;
            app_wren_s = 1'b1;
            state_s    = ST_WR;
          end else begin
            app_cmd_s  = MIG_CMD_READ;
            app_wren_s = 1'b0;
            state_s    = ST_RD_CMD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        // Command and data channels retire independently
        if (cmd_acc_s) begin
          cmd_ok_s = 1'b1;
          app_en_s = 1'b0;
        end else begin
          cmd_ok_s = cmd_ok_r;
        end
        if (dat_acc_s) begin
          dat_ok_s   = 1'b1;
          app_wren_s = 1'b0;
        end else begin
          dat_ok_s = dat_ok_r;
        end
        if ((cmd_ok_r | cmd_acc_s) && (dat_ok_r | dat_acc_s)) begin
          state_s   = ST_DONE;
          p0_done_s = ~gnt_r;
          p1_done_s = gnt_r;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_RD_CMD: begin
        if (cmd_acc_s) begin
          app_en_s = 1'b0;
          state_s  = ST_RD_WAIT;
        end else begin
          state_s = ST_RD_CMD;
        end
      end
      ST_RD_WAIT: begin
        if (bus.app_rd_data_valid) begin
          if (gnt_r) begin
            p1_rdata_s = bus.app_rd_data;
          end else begin
            p0_rdata_s = bus.app_rd_data;
          end
          state_s   = ST_DONE;
          p0_done_s = ~gnt_r;
          p1_done_s = gnt_r;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s    = ST_IDLE;
        app_en_s   = 1'b0;
        app_wren_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
      app_cmd_r    <= 3'b000;
      app_en_r     <= 1'b0;
      app_wren_r   <= 1'b0;
      cmd_ok_r     <= 1'b0;
      dat_ok_r     <= 1'b0;
      p0_done_r    <= 1'b0;
      p1_done_r    <= 1'b0;
      p0_rdata_r   <= {DATA_WIDTH{1'b0}};
      p1_rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      gnt_r        <= gnt_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      app_cmd_r    <= app_cmd_s;
      app_en_r     <= app_en_s;
      app_wren_r   <= app_wren_s;
      cmd_ok_r     <= cmd_ok_s;
      dat_ok_r     <= dat_ok_s;
      p0_done_r    <= p0_done_s;
      p1_done_r    <= p1_done_s;
      p0_rdata_r   <= p0_rdata_s;
      p1_rdata_r   <= p1_rdata_s;
    end
  end

  assign bus.app_addr     = addr_r;
  assign bus.app_cmd      = app_cmd_r;
  assign bus.app_en       = app_en_r;
  assign bus.app_wdf_data = wdata_r;
  assign bus.app_wdf_wren = app_wren_r;
  assign bus.app_wdf_end  = app_wren_r;
  assign bus.app_wdf_mask = {MASK_WIDTH{1'b0}};
  assign bus.p0_done      = p0_done_r;
  assign bus.p1_done      = p1_done_r;
  assign bus.p0_rdata     = p0_rdata_r;
  assign bus.p1_rdata     = p1_rdata_r;

endmodule

// File: tb/tb_mig7_arbiter.sv
// Directed bench for mig7_arbiter: inputs driven and outputs sampled on the
// falling edge of ui_clk; the MIG7 side is driven by hand step by step.
module tb_mig7_arbiter;
  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mig7_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  mig7_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .ui_clk          (clk),
    .ui_clk_sync_rst (rst),
    .bus             (bus)
  );

  int total = 0;
  int bad   = 0;
  int cmd_cnt = 0, dat_cnt = 0, done0_cnt = 0;
  int c0, d0, n0;
  logic en_seen;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] pat_a5, pat_5a;

  // Handshake counters and a one-entry memory holding the last written beat
  always @(posedge clk) begin
    if (bus.app_en && bus.app_rdy) cmd_cnt <= cmd_cnt + 1;
    if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
      dat_cnt <= dat_cnt + 1;
      mem_q   <= bus.app_wdf_data;
    end
    if (bus.p0_done) done0_cnt <= done0_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read served to 'port', starting at a falling edge in IDLE with req set
  task automatic rd_round(input int port, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int lat, input string tag);
    tick();
    chk({tag, "_en"},   DW'(bus.app_en),   DW'(1'b1));
    chk({tag, "_addr"}, DW'(bus.app_addr), DW'(addr));
    chk({tag, "_cmd"},  DW'(bus.app_cmd),  DW'(3'b001));
    tick();
    chk({tag, "_endrop"}, DW'(bus.app_en), DW'(1'b0));
    repeat (lat) tick();
    bus.app_rd_data       = data;
    bus.app_rd_data_valid = 1'b1;
    tick();
    if (port == 0) begin
      chk({tag, "_p0done"}, DW'(bus.p0_done), DW'(1'b1));
      chk({tag, "_p1idle"}, DW'(bus.p1_done), DW'(1'b0));
      chk({tag, "_p0rd"},   bus.p0_rdata,     data);
    end else begin
      chk({tag, "_p1done"}, DW'(bus.p1_done), DW'(1'b1));
      chk({tag, "_p0idle"}, DW'(bus.p0_done), DW'(1'b0));
      chk({tag, "_p1rd"},   bus.p1_rdata,     data);
    end
    bus.app_rd_data_valid = 1'b0;
    tick();
    chk({tag, "_donelow"}, DW'({bus.p1_done, bus.p0_done}), DW'(2'b00));
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    rst = 1'b1;
    bus.init_calib_complete = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_en",    DW'(bus.app_en),       DW'(1'b0));
    chk("rst_wren",  DW'(bus.app_wdf_wren), DW'(1'b0));
    chk("rst_done",  DW'({bus.p1_done, bus.p0_done}), DW'(2'b00));
    chk("rst_p0rd",  bus.p0_rdata, DW'(1'b0));

    // 1: p0 write 0x40, then p1 reads it back with a long read latency
    rst = 1'b0;
    bus.init_calib_complete = 1'b1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 29'h40; bus.p0_wdata = pat_a5;
    n0 = done0_cnt;
    tick();
    chk("t1_en",   DW'(bus.app_en),       DW'(1'b1));
    chk("t1_cmd",  DW'(bus.app_cmd),      DW'(3'b000));
    chk("t1_addr", DW'(bus.app_addr),     DW'(29'h40));
    chk("t1_wren", DW'(bus.app_wdf_wren), DW'(1'b1));
    chk("t1_end",  DW'(bus.app_wdf_end),  DW'(1'b1));
    chk("t1_mask", DW'(bus.app_wdf_mask), DW'(32'h0));
    chk("t1_wdat", bus.app_wdf_data,      pat_a5);
    chk("t1_nodone", DW'(bus.p0_done),    DW'(1'b0));
    tick();
    chk("t1_done", DW'(bus.p0_done), DW'(1'b1));
    chk("t1_idle", DW'({bus.app_en, bus.app_wdf_wren}), DW'(2'b00));
    bus.p0_req = 1'b0;
    tick();
    chk("t1_donecnt", DW'(done0_cnt - n0), DW'(32'd1));
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 29'h40;
    rd_round(1, 29'h40, mem_q, 9, "t1r");
    chk("t1_rdback", bus.p1_rdata, pat_a5);
    bus.p1_req = 1'b0;

    // 2: simultaneous reads right after reset alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 29'h100;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 29'h200;
    rd_round(0, 29'h100, DW'(16'h0011), 0, "t2a");
    rd_round(1, 29'h200, DW'(16'h0022), 0, "t2b");
    rd_round(0, 29'h100, DW'(16'h0033), 0, "t2c");
    rd_round(1, 29'h200, DW'(16'h0044), 0, "t2d");
    chk("t2_p0hold", bus.p0_rdata, DW'(16'h0033));
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;

    // 3: data accepted three cycles before the command
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 29'h80; bus.p0_wdata = pat_5a;
    c0 = cmd_cnt; d0 = dat_cnt; n0 = done0_cnt;
    tick();
    chk("t3_en0",   DW'({bus.app_en, bus.app_wdf_wren}), DW'(2'b11));
    tick();
    chk("t3_en1",   DW'({bus.app_en, bus.app_wdf_wren}), DW'(2'b10));
    chk("t3_nodone", DW'(bus.p0_done), DW'(1'b0));
    tick();
    chk("t3_en2",   DW'({bus.app_en, bus.app_wdf_wren}), DW'(2'b10));
    tick();
    chk("t3_en3",   DW'({bus.app_en, bus.app_wdf_wren}), DW'(2'b10));
    bus.app_rdy = 1'b1;
    tick();
    chk("t3_done",  DW'(bus.p0_done), DW'(1'b1));
    chk("t3_addr",  DW'(bus.app_addr), DW'(29'h80));
    chk("t3_endrop", DW'(bus.app_en), DW'(1'b0));
    bus.p0_req = 1'b0;
    tick();
    chk("t3_cmdcnt",  DW'(cmd_cnt - c0),   DW'(32'd1));
    chk("t3_datcnt",  DW'(dat_cnt - d0),   DW'(32'd1));
    chk("t3_donecnt", DW'(done0_cnt - n0), DW'(32'd1));
    chk("t3_mem",     mem_q, pat_5a);

    // 4: calibration low holds off the grant for 50 cycles
    bus.init_calib_complete = 1'b0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 29'h300;
    en_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      en_seen = en_seen | bus.app_en;
    end
    chk("t4_noen", DW'(en_seen), DW'(1'b0));
    bus.init_calib_complete = 1'b1;
    tick();
    chk("t4_en",   DW'(bus.app_en),   DW'(1'b1));
    chk("t4_addr", DW'(bus.app_addr), DW'(29'h300));
    tick();
    chk("t4_wait", DW'(bus.app_en), DW'(1'b0));

    // 5: reset while waiting for read data; late data must be ignored
    rst = 1'b1;
    bus.p1_req = 1'b0;
    tick();
    chk("t5_rstrd", bus.p1_rdata, DW'(1'b0));
    rst = 1'b0;
    bus.app_rd_data = DW'(16'hDEAD); bus.app_rd_data_valid = 1'b1;
    tick();
    chk("t5_nodone", DW'({bus.p1_done, bus.p0_done}), DW'(2'b00));
    chk("t5_p1rd",   bus.p1_rdata, DW'(1'b0));
    chk("t5_p0rd",   bus.p0_rdata, DW'(1'b0));
    bus.app_rd_data_valid = 1'b0;
    tick();
    chk("t5_idle",   DW'({bus.app_en, bus.p1_done}), DW'(2'b00));

    // 6: low address bits forced to zero; stray valid in IDLE is ignored
    bus.app_rd_data = DW'(16'hBEEF); bus.app_rd_data_valid = 1'b1;
    tick();
    bus.app_rd_data_valid = 1'b0;
    chk("t6_stray0", bus.p0_rdata, DW'(1'b0));
    chk("t6_stray1", bus.p1_rdata, DW'(1'b0));
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 29'h1F;
    rd_round(0, 29'h0, DW'(16'h0077), 0, "t6r");
    bus.p0_we = 1'b1; bus.p0_addr = 29'h1ABC_DE7F; bus.p0_wdata = pat_a5;
    tick();
    chk("t6_waddr", DW'(bus.app_addr), DW'(29'h1ABC_DE60));
    tick();
    chk("t6_wdone", DW'(bus.p0_done), DW'(1'b1));
    bus.p0_req = 1'b0;
    tick();
    chk("t6_p0hold", bus.p0_rdata, DW'(16'h0077));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
